// File: rtl/cc_sched.sv
// Round-robin scheduler sharing one cross-correlator between NREQ sample-stream requesters.
// Grants one requester, streams exactly N sample pairs, waits for done under a watchdog, returns a tagged lag.
module cc_sched #(
    parameter int NREQ    = 4,
    parameter int TW      = 3,
    parameter int N       = 1024,
    parameter int DW      = 16,
    parameter int TIMEOUT = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   smp_m0,
    input  logic [NREQ*DW-1:0]   smp_m1,
    output logic [NREQ-1:0]      gnt,
    output logic                 smp_rd,
    output logic                 cc_rst,
    output logic                 cc_start,
    output logic [DW-1:0]        cc_m0,
    output logic [DW-1:0]        cc_m1,
    input  logic                 cc_done,
    input  logic [15:0]          cc_index,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_index,
    output logic [TW-1:0]        res_tag,
    output logic                 res_err,
    output logic                 busy,
    output logic [15:0]          job_cnt
);
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TW1 = TW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STREAM, S_WAIT, S_RECOVER, S_RESP
    } state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       cnt_r;
    logic [WW-1:0]       wd_r;
    logic [TW-1:0]       rr_r;
    logic [TW-1:0]       pick_s;
    logic [TW:0]         sum_s;
    logic [2*NREQ-1:0]   rot_s;
    logic                any_s;

    // Round-robin pick: rotate requests so the rr pointer sits at bit 0, lowest offset wins
    always_comb begin
        any_s  = |req;
        rot_s  = {req, req} >> rr_r;
        pick_s = rr_r;
        sum_s  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum_s  = {1'b0, rr_r} + TW1'(i);
            sum_s  = (sum_s >= TW1'(NREQ)) ? (sum_s - TW1'(NREQ)) : sum_s;
            pick_s = rot_s[i] ? sum_s[TW-1:0] : pick_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:    state_s = any_s ? S_START : S_IDLE;
            S_START:   state_s = S_STREAM;
            S_STREAM:  state_s = (cnt_r == CW'(N - 1)) ? S_WAIT : S_STREAM;
            S_WAIT: begin
                if (cc_done) begin
                    state_s = S_RESP;
                end else if (wd_r == WW'(TIMEOUT - 1)) begin
                    state_s = S_RECOVER;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RECOVER: state_s = S_RESP;
            S_RESP:    state_s = res_ready ? S_IDLE : S_RESP;
            default:   state_s = S_IDLE;
        endcase
    end

    // Grant, counters, result capture and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt       <= '0;
            res_tag   <= '0;
            res_index <= 16'd0;
            res_err   <= 1'b0;
            job_cnt   <= 16'd0;
            rr_r      <= '0;
            cnt_r     <= '0;
            wd_r      <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (any_s) begin
                        gnt     <= NREQ'(1'b1) << pick_s;
                        res_tag <= pick_s;
                    end
                end
                S_START: cnt_r <= '0;
                S_STREAM: begin
                    cnt_r <= cnt_r + CW'(1);
                    wd_r  <= '0;
                end
                S_WAIT: begin
                    if (cc_done) begin
                        res_index <= cc_index;
                        res_err   <= 1'b0;
                    end else begin
                        wd_r <= wd_r + WW'(1);
                    end
                end
                S_RECOVER: begin
                    res_index <= 16'd0;
                    res_err   <= 1'b1;
                end
                S_RESP: begin
                    if (res_ready) begin
                        gnt     <= '0;
                        rr_r    <= (TW1'(res_tag) == TW1'(NREQ - 1)) ? TW'(0) : (res_tag + TW'(1));
                        job_cnt <= job_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample mux: gnt is one-hot, so OR-ing masked lanes selects the granted requester (0 when idle)
    always_comb begin
        cc_m0 = '0;
        cc_m1 = '0;
        for (int r = 0; r < NREQ; r++) begin
            cc_m0 = cc_m0 | (smp_m0[r*DW +: DW] & {DW{gnt[r]}});
            cc_m1 = cc_m1 | (smp_m1[r*DW +: DW] & {DW{gnt[r]}});
        end
    end

    assign smp_rd    = (state_r == S_STREAM);
    assign cc_start  = (state_r == S_START);
    assign res_valid = (state_r == S_RESP);
    assign busy      = (state_r != S_IDLE);
    assign cc_rst    = ~rst | (state_r == S_RECOVER);

endmodule

// File: tb/tb_cc_sched.sv
// Randomized bench for cc_sched: a transaction-level model predicts grant order, stream length,
// watchdog timing and result contents; the bench also plays the role of the correlator.
module tb_cc_sched;
    localparam int NREQ = 4, TW = 3, N = 16, DW = 16, TIMEOUT = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] smp_m0 = '0, smp_m1 = '0;
    logic [NREQ-1:0]   gnt;
    logic              smp_rd, cc_rst, cc_start, res_valid, res_err, busy;
    logic [DW-1:0]     cc_m0, cc_m1;
    logic              cc_done = 1'b0;
    logic [15:0]       cc_index = 16'd0;
    logic              res_ready = 1'b0;
    logic [15:0]       res_index, job_cnt;
    logic [TW-1:0]     res_tag;

    int          n_chk = 0, n_fail = 0;
    int          rr_m = 0;
    logic [15:0] jobs_m = 16'd0;

    cc_sched #(.NREQ(NREQ), .TW(TW), .N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .smp_m0(smp_m0), .smp_m1(smp_m1),
        .gnt(gnt), .smp_rd(smp_rd), .cc_rst(cc_rst), .cc_start(cc_start),
        .cc_m0(cc_m0), .cc_m1(cc_m1), .cc_done(cc_done), .cc_index(cc_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_tag(res_tag), .res_err(res_err), .busy(busy), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requesting index at or after ptr, wrapping around the ring
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        logic [2*NREQ-1:0] d;
        int k;
        d = {r, r} >> ptr;
        k = 0;
        while (k < NREQ && !d[k]) k++;
        return (ptr + k) % NREQ;
    endfunction

    task automatic rand_smp();
        smp_m0 = {$urandom(), $urandom()};
        smp_m1 = {$urandom(), $urandom()};
    endtask

    task automatic run_job(input logic [NREQ-1:0] reqs, input int lat, input bit stuck, input int hold);
        int          g, rd_cnt, waited;
        logic [15:0] idx, e_idx;
        g   = pick(reqs, rr_m);
        idx = 16'($urandom_range(64)) - 16'd32;
        req = reqs;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(1 << g));
        chk("cc_start", 32'(cc_start), 32'd1);
        chk("tag_at_grant", 32'(res_tag), 32'(g));
        chk("busy", 32'(busy), 32'd1);
        chk("cc_rst_run", 32'(cc_rst), 32'd0);
        req     = NREQ'($urandom());
        cc_done = 1'b0;
        rand_smp();
        rd_cnt = 0;
        for (int c = 0; c < N + 4; c++) begin
            @(negedge clk);
            if (!smp_rd) break;
            chk("cc_m0", 32'(cc_m0), 32'(smp_m0[g*DW +: DW]));
            chk("cc_m1", 32'(cc_m1), 32'(smp_m1[g*DW +: DW]));
            rd_cnt++;
            rand_smp();
        end
        chk("rd_cnt", rd_cnt, N);
        if (stuck) begin
            waited = 0;
            cc_index = 16'($urandom());
            while (!cc_rst && waited < 2 * TIMEOUT) begin
                @(negedge clk);
                waited++;
            end
            chk("wd_cycles", waited, TIMEOUT);
            @(negedge clk);
            chk("cc_rst_pulse", 32'(cc_rst), 32'd0);
        end else begin
            repeat (lat) @(negedge clk);
            cc_index = idx;
            cc_done  = 1'b1;
            @(negedge clk);
        end
        e_idx = stuck ? 16'd0 : idx;
        for (int h = 0; h <= hold; h++) begin
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_index", 32'(res_index), 32'(e_idx));
            chk("res_tag", 32'(res_tag), 32'(g));
            chk("res_err", 32'(res_err), 32'(stuck));
            chk("gnt_hold", 32'(gnt), 32'(1 << g));
            chk("job_cnt_hold", 32'(job_cnt), 32'(jobs_m));
            cc_index  = 16'($urandom());
            res_ready = (h == hold);
            @(negedge clk);
        end
        res_ready = 1'b0;
        jobs_m    = jobs_m + 16'd1;
        rr_m      = (g + 1) % NREQ;
        chk("res_valid_drop", 32'(res_valid), 32'd0);
        chk("gnt_drop", 32'(gnt), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("job_cnt", 32'(job_cnt), 32'(jobs_m));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_cc_rst", 32'(cc_rst), 32'd1);
        chk("rst_smp_rd", 32'(smp_rd), 32'd0);
        chk("rst_cc_start", 32'(cc_start), 32'd0);
        chk("rst_job_cnt", 32'(job_cnt), 32'd0);
        chk("rst_cc_m0", 32'(cc_m0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cc_rst", 32'(cc_rst), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Contention from rr=0: expected order 0,1,3,0
        for (int j = 0; j < 4; j++) run_job(4'b1011, 2, 1'b0, 0);
        // Backpressure, then watchdog abort followed by a normal job
        run_job(4'b0001, 5, 1'b0, 50);
        run_job(4'b0100, 0, 1'b1, 2);
        run_job(4'b0100, TIMEOUT - 2, 1'b0, 1);

        for (int j = 0; j < 30; j++) begin
            run_job(NREQ'($urandom_range(15, 1)), $urandom_range(TIMEOUT - 2, 0),
                    ($urandom_range(7, 0) == 0), $urandom_range(4, 0));
        end

        // Reset in the middle of a stream
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);
        chk("mid_smp_rd", 32'(smp_rd), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'd0);
        chk("mid_smp_rd_off", 32'(smp_rd), 32'd0);
        chk("mid_cc_rst", 32'(cc_rst), 32'd1);
        chk("mid_valid", 32'(res_valid), 32'd0);
        chk("mid_job_cnt", 32'(job_cnt), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        rst    = 1'b1;
        rr_m   = 0;
        jobs_m = 16'd0;
        @(negedge clk);
        chk("post_cc_rst", 32'(cc_rst), 32'd0);
        run_job(4'b1010, 3, 1'b0, 1);
        run_job(4'b1010, 3, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cc_sched.md
Name: cc_sched

Overview:
Round-robin scheduler that shares one cc_1 cross-correlator between NREQ sample-stream requesters. It grants one requester at a time and pulses the correlator start. It then streams exactly N sample pairs from the granted requester into the correlator and waits for done, with a watchdog. The lag index is returned on a valid/ready result port tagged with the requester number.

Parameters:
NREQ, 4, number of requesters (2..8)
TW, 3, tag width, must satisfy 2^TW >= NREQ
N, 1024, sample pairs per job; must equal the correlator's N
DW, 16, sample width
TIMEOUT, 8192, maximum cycles in S_WAIT before abort

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
req  in  NREQ  per-requester job request; held high until the matching gnt bit rises
smp_m0  in  NREQ*DW  packed channel-0 samples, requester r at bits [r*DW +: DW]
smp_m1  in  NREQ*DW  packed channel-1 samples, same packing
gnt  out  NREQ  one-hot grant, held from S_START through end of S_RESP
smp_rd  out  1  sample of granted requester consumed this cycle; requester advances to next pair
cc_rst  out  1  active-high reset to correlator
cc_start  out  1  correlator start pulse
cc_m0  out  DW  sample to correlator channel 0
cc_m1  out  DW  sample to correlator channel 1
cc_done  in  1  correlator done level
cc_index  in  16  correlator best-lag index, valid while cc_done=1
res_valid  out  1  result available
res_ready  in  1  result accepted
res_index  out  16  captured lag index, two's complement
res_tag  out  TW  requester number of this result
res_err  out  1  job aborted by watchdog
busy  out  1  state != S_IDLE
job_cnt  out  16  completed jobs, including aborted ones; wraps at 2^16

Behaviour:
- Reset (rst=0 at a clock edge) applies from any state, including mid-stream:
  - state=S_IDLE, rr pointer=0.
  - gnt, res_valid, cc_start, smp_rd, res_err, busy = 0; res_index, res_tag, job_cnt = 0.
  - cc_rst = 1 combinationally while rst=0, so the correlator is returned to Idle together with the scheduler.
- cc_rst = ~rst | (state==S_RECOVER).
- cc_m0/cc_m1 = combinational mux of smp_m0/smp_m1 by the granted index; 0 when gnt=0.
- States:
  - S_IDLE: if any req bit is set, pick the first set bit searching from the rr pointer upward with wrap. Latch gnt and res_tag, go to S_START. No req: stay.
  - S_START (1 cycle): cc_start=1, sample counter cnt=0, go to S_STREAM.
  - S_STREAM (exactly N cycles): smp_rd=1 every cycle, no stalls; the requester must present a fresh pair every cycle. cnt increments; at cnt==N-1 go to S_WAIT with wd=0. The correlator is in ReadInputs for exactly these N cycles (write address = cnt).
  - S_WAIT: if cc_done=1, capture res_index=cc_index, res_err=0, go to S_RESP. Otherwise wd increments; at wd==TIMEOUT-1 go to S_RECOVER.
  - S_RECOVER (1 cycle): cc_rst=1, res_index=0, res_err=1, go to S_RESP.
  - S_RESP: res_valid=1, and res_index/res_tag/res_err are held stable. On res_valid & res_ready:
    - clear gnt;
    - rr pointer = granted index + 1 (mod NREQ);
    - job_cnt += 1;
    - go to S_IDLE (res_valid low next cycle).
- Grant latency: req rising in S_IDLE gives gnt one cycle later; cc_start is high during that same cycle.
- req bits are sampled only in S_IDLE. Deasserting req after grant has no effect: the job completes and returns a result.
- Simultaneous requests: round-robin order. A requester that was just served is lowest priority next time.
- Back-to-back jobs: minimum spacing between cc_start pulses is N+2+(correlator compute time)+1 cycles. No overlap is possible.
- Stale cc_done from a previous job is ignored outside S_WAIT. It is never seen in S_WAIT because the correlator leaves Done on cc_start.
- cc_index is passed through unmodified (signed lag -32..32).

Test Plan:
- Single requester: req=4'b0001, ramps smp_m0[k]=k, smp_m1[k]=k shifted by +5 -> gnt=0001 one cycle after req, cc_start 1 cycle, smp_rd high exactly 1024 cycles, then res_valid with res_tag=0, res_index=the correlator's reported lag, res_err=0, job_cnt=1.
- Contention: req=4'b1011 held, rr=0 -> service order tags 0,1,3,0; each result returned before the next gnt.
- Backpressure: hold res_ready=0 for 50 cycles in S_RESP -> res_valid, res_index, res_tag stable; no new gnt; gnt drops the cycle after the handshake.
- Watchdog: model cc_done stuck 0 -> after 8192 S_WAIT cycles, cc_rst pulses 1 cycle, result res_err=1, res_index=0, job_cnt increments. A following job completes normally.
- Reset mid-stream: rst=0 at cnt=500 -> next cycle gnt=0, smp_rd=0, cc_rst=1 while rst low, res_valid=0, job_cnt=0. After release, a new req is served from rr=0.
- Wrap: preload 65535 jobs via fast cc model -> job_cnt wraps to 0 on the next completion.
